// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a small output FIFO; a word is visible one edge after its last bit.
// Consumer backpressure via out_ready; words completing into a full FIFO are dropped and flagged in sticky overflow.

module sipo_rx_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] word;
  logic             push, pop;
  logic [WIDTH-1:0] head_dat;
  logic             fifo_empty, fifo_full;

  assign word = {serial_in, shreg_q[WIDTH-1:1]};
  assign pop  = out_valid && out_ready;

  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    // Flush outranks a same-edge bit, even a completing one.
    if (flush) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (bit_valid) begin
      shreg_d = word;
      if (cnt_q == CNT_LAST) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    overflow_d = overflow_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sipo_rx_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (word),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign out_valid    = !fifo_empty;
  assign parallel_out = out_valid ? head_dat : '0;
  assign busy         = (cnt_q != '0);
  assign overflow     = overflow_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx (WIDTH=4, DEPTH=2): vector table plus directed sequences, words scored through a queue.
module tb_sipo_rx;
  logic       clk, reset, serial_in, bit_valid, flush, out_ready;
  logic [3:0] parallel_out;
  logic       out_valid, busy, overflow;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_head;

  typedef struct {
    logic       si, bv, rdy, cmpl;
    logic       e_vld;
    logic [3:0] e_dat;
    logic       e_busy, e_ovf;
  } vec_t;
  vec_t vq[$];

  sipo_rx #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .flush(flush), .parallel_out(parallel_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input bit exp_push);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && exp_push) exp_q.push_back(w);
      send_bit(w[i]);
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && out_valid; i++) step();
    out_ready = 1'b0;
    check({name, "_vld"}, out_valid, 0);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Every accepted pop is compared against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no word", parallel_out);
      end else begin
        exp_head = exp_q.pop_front();
        check("pop_data", parallel_out, exp_head);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_vld", out_valid, 0);
    check("rst_dat", parallel_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);

    // si bv rdy cmpl | vld dat busy ovf
    vq.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
    vq.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
    vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
    vq.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    // Gapped 1,1,0,1 with three idle cycles between bits.
    for (int b = 0; b < 4; b++) begin
      logic [3:0] gw;
      gw = 4'b1011;
      if (b == 3) begin
        vq.push_back(vec_t'{gw[b], 1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0});
      end else begin
        vq.push_back(vec_t'{gw[b], 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
        for (int g = 0; g < 3; g++)
          vq.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
      end
    end
    for (int i = 0; i < vq.size(); i++) begin
      serial_in = vq[i].si;
      bit_valid = vq[i].bv;
      out_ready = vq[i].rdy;
      if (vq[i].cmpl) exp_q.push_back(vq[i].e_dat);
      step();
      check($sformatf("vec%0d_vld", i), out_valid, vq[i].e_vld);
      check($sformatf("vec%0d_dat", i), parallel_out, vq[i].e_dat);
      check($sformatf("vec%0d_busy", i), busy, vq[i].e_busy);
      check($sformatf("vec%0d_ovf", i), overflow, vq[i].e_ovf);
    end
    bit_valid = 1'b0;
    out_ready = 1'b0;
    drain("gap_drain");

    // Backpressure: third word is dropped.
    send_word(4'h1, 1);
    send_word(4'h2, 1);
    check("bp_ovf_before", overflow, 0);
    send_word(4'h3, 0);
    check("bp_ovf", overflow, 1);
    check("bp_head", parallel_out, 4'h1);
    drain("bp_drain");
    check("bp_ovf_sticky", overflow, 1);
    do_reset();
    check("bp_ovf_clr", overflow, 0);

    // Full FIFO with a pop on the completing edge.
    send_word(4'h1, 1);
    send_word(4'h2, 1);
    check("fp_full_vld", out_valid, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    out_ready = 1'b1;
    exp_q.push_back(4'h3);
    send_bit(1'b0);
    check("fp_ovf", overflow, 0);
    check("fp_head", parallel_out, 4'h2);
    drain("fp_drain");

    // Flush after two bits, then a fresh word.
    send_bit(1'b1);
    send_bit(1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_busy", busy, 0);
    send_word(4'b0001, 1);
    check("fl_word", parallel_out, 4'h1);
    drain("fl_drain");

    // Flush together with the completing bit.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    serial_in = 1'b1; bit_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; bit_valid = 1'b0;
    check("flc_busy", busy, 0);
    check("flc_vld", out_valid, 0);
    send_word(4'hA, 1);
    check("flc_next", parallel_out, 4'hA);
    drain("flc_drain");

    // Reset mid-operation with queued words, overflow set and two bits assembled.
    send_word(4'h5, 1);
    send_word(4'h7, 1);
    send_word(4'h9, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("rm_busy_pre", busy, 1);
    check("rm_ovf_pre", overflow, 1);
    reset = 1'b1; serial_in = 1'b1; bit_valid = 1'b1;
    step();
    reset = 1'b0; bit_valid = 1'b0;
    exp_q.delete();
    check("rm_vld", out_valid, 0);
    check("rm_dat", parallel_out, 0);
    check("rm_busy", busy, 0);
    check("rm_ovf", overflow, 0);
    send_word(4'h6, 1);
    check("rm_clean_vld", out_valid, 1);
    check("rm_clean_dat", parallel_out, 4'h6);
    drain("rm_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
